// File: rtl/axi4stream_output_serializer_if.sv
// Word-in / AXI4-Stream-out handshake bundle for axi4stream_output_serializer.
// master: the serializer side; slave: the word source plus stream sink side.
interface axi4stream_output_serializer_if #(
  parameter int AXI_PACKET_SIZE = 8,
  parameter int BUFFER_SIZE     = 40
);
  logic [BUFFER_SIZE-1:0]     in_buffer;
  logic                       in_valid;
  logic                       in_ready;
  logic [AXI_PACKET_SIZE-1:0] tdata;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic                       busy;

  modport master (
    input  in_buffer, in_valid, tready,
    output in_ready, tdata, tvalid, tlast, busy
  );

  modport slave (
    output in_buffer, in_valid, tready,
    input  in_ready, tdata, tvalid, tlast, busy
  );
endinterface

// File: rtl/axi4stream_output_serializer.sv
// Replays one row-packed word as AXI4-Stream beats, each row starting on a fresh beat.
// Define OUTPUT_SERIALIZER_TLAST_PER_ROW_EN to assert tlast at the end of every row.
module axi4stream_output_serializer #(
  parameter int AXI_PACKET_SIZE = 8,
  parameter int BUFFER_SIZE     = 40,
  parameter int ROW_SIZE        = 20,
  parameter int N_ROWS          = 2
) (
  input  logic aclk,
  input  logic areset,
  axi4stream_output_serializer_if.master io
);

  localparam int BEATS_PER_ROW = (ROW_SIZE + AXI_PACKET_SIZE - 1) / AXI_PACKET_SIZE;
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int BW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(N_ROWS - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_ROW - 1);

`ifdef OUTPUT_SERIALIZER_TLAST_PER_ROW_EN
  localparam bit TLAST_EVERY_ROW = 1'b1;
`else
  localparam bit TLAST_EVERY_ROW = 1'b0;
`endif

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                 state_q;
  logic [BUFFER_SIZE-1:0]     shadow_q;
  logic [RW-1:0]              row_q, row_n;
  logic [BW-1:0]              beat_q, beat_n;
  logic [AXI_PACKET_SIZE-1:0] tdata_q;
  logic                       tvalid_q, tlast_q, busy_q;
  logic                       beat_end, word_end;

  // Bits past the row end are masked so the next row never leaks into a padded beat.
  function automatic logic [AXI_PACKET_SIZE-1:0] beat_slice(
    input logic [BUFFER_SIZE-1:0] word,
    input logic [RW-1:0]          r,
    input logic [BW-1:0]          b
  );
    logic [AXI_PACKET_SIZE-1:0] mask;
    int remain;
    remain = ROW_SIZE - int'(b) * AXI_PACKET_SIZE;
    mask = (remain >= AXI_PACKET_SIZE) ? '1
         : ({AXI_PACKET_SIZE{1'b1}} >> (AXI_PACKET_SIZE - remain));
    return AXI_PACKET_SIZE'(word >> (int'(r) * ROW_SIZE + int'(b) * AXI_PACKET_SIZE)) & mask;
  endfunction

  function automatic logic tlast_rule(input logic row_end, input logic final_row);
    return row_end && (final_row || TLAST_EVERY_ROW);
  endfunction

  always_comb begin
    beat_end = (beat_q == LAST_BEAT);
    word_end = beat_end && (row_q == LAST_ROW);
    beat_n   = beat_end ? '0 : beat_q + 1'b1;
    row_n    = beat_end ? row_q + 1'b1 : row_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      row_q    <= '0;
      beat_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            state_q  <= STREAM;
            shadow_q <= io.in_buffer;
            row_q    <= '0;
            beat_q   <= '0;
            tdata_q  <= beat_slice(io.in_buffer, '0, '0);
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            tlast_q  <= tlast_rule(LAST_BEAT == '0, LAST_ROW == '0);
          end
        end
        default: begin
          if (tvalid_q && io.tready) begin
            if (word_end) begin
              state_q  <= IDLE;
              row_q    <= '0;
              beat_q   <= '0;
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              row_q   <= row_n;
              beat_q  <= beat_n;
              tdata_q <= beat_slice(shadow_q, row_n, beat_n);
              tlast_q <= tlast_rule(beat_n == LAST_BEAT, row_n == LAST_ROW);
            end
          end
        end
      endcase
    end
  end

  // Reset must hold in_ready low during the reset cycle itself, not just after it.
  assign io.in_ready = (state_q == IDLE) && !areset;
  assign io.tdata    = tdata_q;
  assign io.tvalid   = tvalid_q;
  assign io.tlast    = tlast_q;
  assign io.busy     = busy_q;

endmodule

// File: tb/tb_axi4stream_output_serializer.sv
// Scoreboard bench: driver pushes expected beats on acceptance, monitor checks every cycle.
module tb_axi4stream_output_serializer;

  localparam int AXI = 8;
  localparam int BUF = 40;
  localparam int ROW = 20;
  localparam int NR  = 2;
  localparam int BPR = 3;

`ifdef OUTPUT_SERIALIZER_TLAST_PER_ROW_EN
  localparam bit PER_ROW = 1'b1;
`else
  localparam bit PER_ROW = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic  aclk = 1'b0;
  logic  areset;
  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    stall_req = 0;
  bit    rand_mode = 1'b0;

  axi4stream_output_serializer_if #(.AXI_PACKET_SIZE(AXI), .BUFFER_SIZE(BUF)) sif ();

  axi4stream_output_serializer #(
    .AXI_PACKET_SIZE(AXI), .BUFFER_SIZE(BUF), .ROW_SIZE(ROW), .N_ROWS(NR)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .io     (sif)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: slice the word into rows, then each row into zero-padded bytes.
  task automatic push_model(input logic [BUF-1:0] w);
    longint unsigned wv, rowv;
    beat_t e;
    wv = {24'd0, w};
    for (int r = 0; r < NR; r++) begin
      rowv = (wv >> (r * ROW)) % (64'd1 << ROW);
      for (int b = 0; b < BPR; b++) begin
        e.d = 8'((rowv >> (b * AXI)) % 256);
        e.l = (b == BPR - 1) && (PER_ROW || r == NR - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_table(input logic [47:0] tbl);
    beat_t e;
    for (int i = 0; i < NR * BPR; i++) begin
      e.d = tbl[i*8 +: 8];
      e.l = (i % BPR == BPR - 1) && (PER_ROW || i / BPR == NR - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic offer(input logic [BUF-1:0] w, input bit use_tbl,
                       input logic [47:0] tbl, input bit keep);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    sif.in_buffer = w;
    sif.in_valid  = 1'b1;
    while (!acc && n < 300) begin
      @(negedge aclk);
      if (sif.in_ready === 1'b1 && areset === 1'b0) acc = 1'b1;
      else n++;
    end
    chk("accept_timeout", {63'd0, acc}, 64'd1);
    if (acc) begin
      @(posedge aclk);
      if (use_tbl) push_table(tbl);
      else push_model(w);
      #1;
      sif.in_buffer = 40'({$urandom, $urandom});
      sif.in_valid  = keep;
    end else begin
      sif.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Sink: always ready, random, or a directed stall while beat BC is presented.
  initial begin
    sif.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (stall_req > 0 && sif.tvalid === 1'b1 && sif.tdata === 8'hBC) begin
        sif.tready = 1'b0;
        stall_req--;
      end else begin
        sif.tready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: cycle-exact check of handshake outputs against the scoreboard.
  initial begin
    bit act;
    bit prev_rst;
    prev_rst = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("in_ready_in_reset", {63'd0, sif.in_ready}, 64'd0);
        prev_rst = 1'b1;
      end else begin
        act = (exp_q.size() != 0);
        chk("tvalid", {63'd0, sif.tvalid}, {63'd0, act});
        chk("busy", {63'd0, sif.busy}, {63'd0, act});
        chk("in_ready", {63'd0, sif.in_ready}, {63'd0, !act});
        if (prev_rst) chk("tdata_after_reset", {56'd0, sif.tdata}, 64'd0);
        if (act) begin
          chk("tdata", {56'd0, sif.tdata}, {56'd0, exp_q[0].d});
          chk("tlast", {63'd0, sif.tlast}, {63'd0, exp_q[0].l});
          if (sif.tready) void'(exp_q.pop_front());
        end else begin
          chk("tlast_idle", {63'd0, sif.tlast}, 64'd0);
        end
        prev_rst = 1'b0;
      end
    end
  end

  initial begin
    int n;
    bit found;
    bit keep;
    areset        = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_buffer = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Basic word and padding word
    offer(40'h12345_ABCDE, 1'b1, 48'h01_23_45_0A_BC_DE, 1'b0);
    wait_drain();
    offer(40'hFFFFF_FFFFF, 1'b1, 48'h0F_FF_FF_0F_FF_FF, 1'b0);
    wait_drain();

    // Three-cycle stall on BC
    stall_req = 3;
    offer(40'h12345_ABCDE, 1'b1, 48'h01_23_45_0A_BC_DE, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held and in_buffer scrambled mid-stream
    offer(40'hA5A5A_5A5A5, 1'b0, 48'd0, 1'b1);
    offer(40'h0F0F0_C3C3C, 1'b0, 48'd0, 1'b0);
    wait_drain();

    // Reset pulse right after the BC handshake
    offer(40'h12345_ABCDE, 1'b1, 48'h01_23_45_0A_BC_DE, 1'b0);
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge aclk);
      if (sif.tvalid === 1'b1 && sif.tready === 1'b1 && sif.tdata === 8'hBC) found = 1'b1;
      else n++;
    end
    chk("bc_seen_before_reset", {63'd0, found}, 64'd1);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    exp_q.delete();
    #1;
    areset = 1'b0;
    offer(40'h12345_ABCDE, 1'b1, 48'h01_23_45_0A_BC_DE, 1'b0);
    wait_drain();

    // Random words, random sink stalls, random source gaps
    rand_mode = 1'b1;
    repeat (40) begin
      keep = 1'($urandom_range(0, 1));
      offer(40'({$urandom, $urandom}), 1'b0, 48'd0, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge aclk);
          #1;
        end
      end
    end
    sif.in_valid = 1'b0;
    wait_drain();
    rand_mode = 1'b0;
    repeat (3) @(posedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
